uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. Each completed frame is captured as one entry: the 9-bit word (8 data bits plus the parity bit) and its frame-error and parity-error flags. The host/register side drains entries through a first-word-fall-through read port. The block returns full status to the receiver for RTS hardware flow control and keeps sticky overflow/underflow flags for the status register.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
AF_LEVEL, DEPTH-2, fill level at or above which o_almost_full asserts; range 1..DEPTH

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_wr_en  in  1  receiver frame-done strobe; one write per cycle high
i_wr_data  in  9  received word, bit 8 = parity bit
i_wr_frame_err  in  1  frame error for this word
i_wr_parity_err  in  1  parity error for this word
o_full  out  1  level == DEPTH; drives the receiver's fifo-full input
o_almost_full  out  1  level >= AF_LEVEL
i_rd_en  in  1  pop head entry
o_rd_data  out  9  head word; valid while !o_empty
o_rd_frame_err  out  1  head entry's frame-error flag
o_rd_parity_err  out  1  head entry's parity-error flag
o_empty  out  1  level == 0
o_level  out  $clog2(DEPTH)+1  current fill count, 0..DEPTH
i_flush  in  1  synchronous discard of all entries
i_clr_flags  in  1  clear sticky error flags
o_overflow  out  1  sticky: a write was dropped
o_underflow  out  1  sticky: a read was issued while empty

Behaviour:
- Reset (async assert, sync release): pointers 0, o_level 0, o_empty 1, o_full 0, o_almost_full 0, o_overflow 0, o_underflow 0, o_rd_* 0. Storage contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits wide, with a wrap bit.
  - Empty when the pointers are equal.
  - Full when the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally at 2*DEPTH.
- o_level = wr_ptr - rd_ptr (modulo). All status outputs are registered or derived from registered pointers only; there is no combinational path from i_wr_en or i_rd_en to any output.
- FWFT read port:
  - o_rd_* presents the entry at rd_ptr whenever !o_empty.
  - The first write to an empty FIFO is visible on o_rd_* in the cycle after the write edge.
  - When o_empty, o_rd_* is 0.
- Write accepted when i_wr_en && (!o_full || rd_accepted). The entry is stored at wr_ptr and wr_ptr increments.
- Read accepted when i_rd_en && !o_empty. rd_ptr increments.
- Simultaneous write and read:
  - Full: both accepted; level stays DEPTH; the newly written entry is not lost.
  - Empty: the write is accepted, the read is rejected (underflow set); level becomes 1.
  - Otherwise: both accepted; level unchanged.
- Overflow: i_wr_en while full and no accepted read. The write is dropped, storage is unchanged, and o_overflow is set next cycle.
- Underflow: i_rd_en while empty sets o_underflow next cycle. Pointers are unchanged.
- i_flush:
  - Sets rd_ptr to wr_ptr's current value in one cycle, so level becomes 0.
  - Takes priority over i_rd_en and i_wr_en in the same cycle; the write that cycle is dropped without setting overflow.
  - Sticky flags are unaffected.
- i_clr_flags clears both sticky flags. If a new overflow/underflow event occurs in the same cycle, the set wins.
- o_full feeds the receiver directly. The receiver samples it only in IDLE, so one cycle of registered latency is acceptable; words arriving while full are counted as overflow.

Decomposition:
- uart_pkg gains:
  - typedef struct packed rx_fifo_entry_t {frame_err, parity_err, logic [8:0] data} (11 bits)
  - localparam UART_RX_FIFO_DEPTH = 16
- Sub-module uart_fifo_mem: generic DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port, no reset. The future TX FIFO reuses it.
- Pointer, level and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset, then write 0x0A5 (flags 0,0) -> next cycle o_empty=0, o_level=1, o_rd_data=0x0A5; pulse i_rd_en -> o_empty=1, o_rd_data=0.
- Write 16 words 0x100..0x10F (DEPTH=16) -> o_almost_full at level 14, o_full at level 16. A 17th write (0x1FF) -> o_overflow=1. Drain all -> 0x100..0x10F in order, 0x1FF absent.
- Full FIFO, i_wr_en and i_rd_en in the same cycle with 0x055 -> level stays 16; after draining, 0x055 is the last entry; o_overflow stays 0.
- Empty FIFO, i_rd_en with i_wr_en (0x033) -> o_underflow=1, level=1, head=0x033. i_clr_flags -> o_underflow=0.
- Write 0x0F0 with frame_err=1 and 0x00F with parity_err=1 -> each pops with its own flags, in order.
- Level 5 with i_flush and i_wr_en together -> level 0, o_empty=1, o_overflow=0. Async i_rst mid-stream -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Holds the RX FIFO entry layout and its default depth.
package uart_pkg;

  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [8:0] data;
  } rx_fifo_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Generic DEPTH x WIDTH register array, no reset.
// Ports: i_clk, i_we/i_waddr/i_wdata (sync write), i_raddr/o_rdata (async read).
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: FWFT read port, full/almost-full, sticky ovf/udf.
// Ports: i_clk/i_rst, write (i_wr_*), read (i_rd_en, o_rd_*), status, i_flush, i_clr_flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = UART_RX_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [8:0]    i_wr_data,
  input  logic          i_wr_frame_err,
  input  logic          i_wr_parity_err,
  output logic          o_full,
  output logic          o_almost_full,
  input  logic          i_rd_en,
  output logic [8:0]    o_rd_data,
  output logic          o_rd_frame_err,
  output logic          o_rd_parity_err,
  output logic          o_empty,
  output logic [PW-1:0] o_level,
  input  logic          i_flush,
  input  logic          i_clr_flags,
  output logic          o_overflow,
  output logic          o_underflow
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          empty, full;
  logic          rd_acc, wr_acc;
  logic          ovf_evt, udf_evt;
  logic [PW-1:0] level;

  rx_fifo_entry_t wr_entry, rd_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
              && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  // Flush wins over both ports and raises no event flags.
  assign rd_acc  = i_rd_en && !empty && !i_flush;
  // When full, a same-cycle pop frees the slot being written.
  assign wr_acc  = i_wr_en && (!full || rd_acc) && !i_flush;
  assign ovf_evt = i_wr_en && full && !rd_acc && !i_flush;
  assign udf_evt = i_rd_en && empty && !i_flush;

  assign wr_entry = '{frame_err:  i_wr_frame_err,
                      parity_err: i_wr_parity_err,
                      data:       i_wr_data};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A new event in the clear cycle keeps the flag set.
    ovf_d = ovf_evt || (ovf_q && !i_clr_flags);
    udf_d = udf_evt || (udf_q && !i_clr_flags);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rx_fifo_entry_t))
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wr_acc),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (wr_entry),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (rd_entry)
  );

  assign o_empty         = empty;
  assign o_full          = full;
  assign o_level         = level;
  assign o_almost_full   = (level >= PW'(AF_LEVEL));
  assign o_overflow      = ovf_q;
  assign o_underflow     = udf_q;
  assign o_rd_data       = empty ? '0   : rd_entry.data;
  assign o_rd_frame_err  = empty ? 1'b0 : rd_entry.frame_err;
  assign o_rd_parity_err = empty ? 1'b0 : rd_entry.parity_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// Directed plan followed by random traffic against a queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] wr_data = '0;
  logic       wr_fe = 1'b0;
  logic       wr_pe = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic       full, afull, empty, ovf, udf;
  logic       rd_fe, rd_pe;
  logic [8:0] rd_data;
  logic [4:0] level;

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_en         (wr_en),
    .i_wr_data       (wr_data),
    .i_wr_frame_err  (wr_fe),
    .i_wr_parity_err (wr_pe),
    .o_full          (full),
    .o_almost_full   (afull),
    .i_rd_en         (rd_en),
    .o_rd_data       (rd_data),
    .o_rd_frame_err  (rd_fe),
    .o_rd_parity_err (rd_pe),
    .o_empty         (empty),
    .o_level         (level),
    .i_flush         (flush),
    .i_clr_flags     (clr),
    .o_overflow      (ovf),
    .o_underflow     (udf)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [10:0] h;
    h = (mq.size() > 0) ? mq[0] : 11'h0;
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("afull", 32'(afull), 32'(mq.size() >= AF));
    chk("level", 32'(level), 32'(mq.size()));
    chk("rd_data", 32'(rd_data), 32'(h[8:0]));
    chk("rd_fe", 32'(rd_fe), 32'(h[10]));
    chk("rd_pe", 32'(rd_pe), 32'(h[9]));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
  endtask

  // One clock cycle with the given inputs; the model follows the
  // behavioural rules, then every output is compared.
  task automatic step(bit w, logic [8:0] d, bit fe, bit pe,
                      bit r, bit fl, bit c);
    bit rd_ok, wr_ok, e_ovf, e_udf;
    @(negedge clk);
    wr_en = w; wr_data = d; wr_fe = fe; wr_pe = pe;
    rd_en = r; flush = fl; clr = c;
    @(posedge clk);
    e_ovf = 0;
    e_udf = 0;
    if (fl) begin
      mq.delete();
    end else begin
      rd_ok = r && mq.size() > 0;
      wr_ok = w && (mq.size() < DEPTH || rd_ok);
      e_udf = r && mq.size() == 0;
      e_ovf = w && !wr_ok;
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) mq.push_back({fe, pe, d});
    end
    m_ovf = e_ovf || (m_ovf && !c);
    m_udf = e_udf || (m_udf && !c);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 9'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (mq.size() > 0) step(0, 9'h0, 0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // single word round trip
    step(1, 9'h0A5, 0, 0, 0, 0, 0);
    chk("head_0A5", 32'(rd_data), 32'h0A5);
    step(0, 9'h0, 0, 0, 1, 0, 0);

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 9'(9'h100 + i), 0, 0, 0, 0, 0);
    step(1, 9'h1FF, 0, 0, 0, 0, 0);
    chk("ovf_set", 32'(ovf), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(rd_data), 32'(9'h100 + i));
      step(0, 9'h0, 0, 0, 1, 0, 0);
    end
    step(0, 9'h0, 0, 0, 0, 0, 1);

    // full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) step(1, 9'(i), 0, 0, 0, 0, 0);
    step(1, 9'h055, 0, 0, 1, 0, 0);
    chk("full_rw_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH - 1; i++) step(0, 9'h0, 0, 0, 1, 0, 0);
    chk("last_055", 32'(rd_data), 32'h055);
    step(0, 9'h0, 0, 0, 1, 0, 0);

    // empty with simultaneous read and write
    step(1, 9'h033, 0, 0, 1, 0, 0);
    chk("udf_set", 32'(udf), 32'h1);
    step(0, 9'h0, 0, 0, 0, 0, 1);
    drain();

    // per-entry error flags
    step(1, 9'h0F0, 1, 0, 0, 0, 0);
    step(1, 9'h00F, 0, 1, 0, 0, 0);
    step(0, 9'h0, 0, 0, 1, 0, 0);
    step(0, 9'h0, 0, 0, 1, 0, 0);

    // flush with a write in the same cycle
    for (int i = 0; i < 5; i++) step(1, 9'(9'h020 + i), 0, 0, 0, 0, 0);
    step(1, 9'h1AA, 0, 0, 1, 1, 0);
    idle();

    // async reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 9'(9'h040 + i), 0, 0, 0, 0, 0);
    step(0, 9'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    wr_en = 0; rd_en = 1; flush = 0; clr = 0;
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    rd_en = 0;
    idle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 99) < 55),
           9'($urandom),
           bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 99) < 3),
           bit'($urandom_range(0, 99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
